// File: rtl/mem_io_responder.sv
// mem_io_responder: byte-wide RAM plus memory-mapped I/O window (RX byte, TX FIFO,
// cycle counter, stop flag) answering the CPU's memory bus with one-cycle read latency.
module mem_io_responder #(
    parameter int unsigned RAM_ADDR_WIDTH = 17,
    parameter int unsigned TX_DEPTH_LOG2  = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        program_stop,
    output logic        tx_overflow
);

    localparam int unsigned RAM_WORDS = 1 << RAM_ADDR_WIDTH;
    localparam int unsigned DEPTH     = 1 << TX_DEPTH_LOG2;
    localparam int unsigned CW        = TX_DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
    localparam logic [CW-1:0] NEARLY_C = CW'(DEPTH - 1);

    logic [7:0]                ram [RAM_WORDS];
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic                      is_io;
    logic [2:0]                io_off;
    logic                      ram_wr, ram_rd, io_wr, io_rd;
    logic                      push, push_ok, pop;
    logic [7:0]                push_data;
    logic                      rx_clr, snap_ld, stop_set;
    logic [7:0]                io_rdata;

    logic [31:0]               counter;
    logic [31:0]               snap;
    logic                      rx_full;
    logic [7:0]                rx_buf;

    logic [7:0]                tx_mem [DEPTH];
    logic [TX_DEPTH_LOG2-1:0]  wptr, rptr;
    logic [CW-1:0]             count;

    // Upper address bits beyond the RAM index and I/O decode are don't-care.
    logic unused_addr;
    assign unused_addr = ^mem_a;

    // Bus access qualification and I/O side-effect decode.
    always_comb begin
        is_io     = (mem_a[17:16] == 2'b11);
        io_off    = mem_a[2:0];
        ram_idx   = mem_a[RAM_ADDR_WIDTH-1:0];
        ram_wr    = rdy_in && !is_io && mem_wr;
        ram_rd    = rdy_in && !is_io && !mem_wr;
        io_wr     = rdy_in && is_io && mem_wr;
        io_rd     = rdy_in && is_io && !mem_wr;
        push      = io_wr && (((io_off == 3'd0) && (mem_dout != 8'd0)) || (io_off == 3'd4));
        push_data = (io_off == 3'd4) ? 8'd0 : mem_dout;
        rx_clr    = io_rd && (io_off == 3'd0);
        snap_ld   = io_rd && (io_off == 3'd4);
        stop_set  = io_wr && (io_off == 3'd4);
        pop       = tx_valid && tx_ready;
        // A push into a full FIFO survives only if the head leaves in the same cycle.
        push_ok   = push && ((count != FULL_C) || pop);
    end

    // I/O read byte selected by the low address bits.
    always_comb begin
        io_rdata = 8'd0;
        case (io_off)
            3'd0:    io_rdata = rx_full ? rx_buf : 8'd0;
            3'd4:    io_rdata = counter[7:0];
            3'd5:    io_rdata = snap[15:8];
            3'd6:    io_rdata = snap[23:16];
            3'd7:    io_rdata = snap[31:24];
            default: io_rdata = 8'd0;
        endcase
    end

    // RAM write port; contents are deliberately left unreset.
    always_ff @(posedge clk_in) begin
        if (ram_wr) begin
            ram[ram_idx] <= mem_dout;
        end
    end

    // Registered read data; holds its value on cycles without a read.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_din <= 8'd0;
        end else if (ram_rd) begin
            mem_din <= ram[ram_idx];
        end else if (io_rd) begin
            mem_din <= io_rdata;
        end
    end

    // Free-running cycle counter and snapshot taken on a low-byte read.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            counter <= 32'd0;
            snap    <= 32'd0;
        end else begin
            counter <= counter + 32'd1;
            if (snap_ld) begin
                snap <= counter;
            end
        end
    end

    // RX holding register: load on handshake, clear on CPU read.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_full <= 1'b0;
            rx_buf  <= 8'd0;
        end else if (rx_valid && !rx_full) begin
            rx_full <= 1'b1;
            rx_buf  <= rx_data;
        end else if (rx_clr) begin
            rx_full <= 1'b0;
        end
    end

    // Sticky program-stop flag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            program_stop <= 1'b0;
        end else if (stop_set) begin
            program_stop <= 1'b1;
        end
    end

    // TX FIFO storage.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            tx_mem[wptr] <= push_data;
        end
    end

    // TX FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (!push_ok && pop) begin
                count <= count - 1'b1;
            end
            if (push && !push_ok) begin
                tx_overflow <= 1'b1;
            end
        end
    end

    // Status outputs decoded from registered state.
    assign rx_ready       = !rx_full;
    assign tx_valid       = (count != '0);
    assign tx_data        = tx_valid ? tx_mem[rptr] : 8'd0;
    assign io_buffer_full = (count >= NEARLY_C);

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder with read-data and TX-stream scoreboards.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b0;
    logic [31:0] mem_a = 32'd0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_dout = 8'd0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        program_stop;
    logic        tx_overflow;

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .program_stop   (program_stop),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  rd_q[$];
    string       rd_tag[$];
    logic [7:0]  tx_q[$];
    logic        rd_pend = 1'b0;
    logic [31:0] tb_cyc = 32'd0;
    logic [31:0] snap_exp;

    // Reference cycle count: zero while in reset, +1 per clock afterwards.
    always @(posedge clk_in) tb_cyc <= rst_in ? 32'd0 : tb_cyc + 32'd1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: score any TX pop before the edge, score a pending read after it,
    // then leave the bus idle.
    task automatic tick();
        logic       had;
        logic [7:0] e;
        string      t;
        had = rd_pend;
        if (tx_valid === 1'b1 && tx_ready && !rst_in) begin
            chk("tx_pop_expected", 32'(tx_q.size() != 0), 32'd1);
            if (tx_q.size() != 0) begin
                e = tx_q.pop_front();
                chk("tx_data", 32'(tx_data), 32'(e));
            end
        end
        @(posedge clk_in);
        #1;
        if (had) begin
            rd_pend = 1'b0;
            e = rd_q.pop_front();
            t = rd_tag.pop_front();
            chk(t, 32'(mem_din), 32'(e));
        end
        rdy_in = 1'b0;
        mem_wr = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d, input logic r);
        rdy_in   = r;
        mem_a    = a;
        mem_wr   = 1'b1;
        mem_dout = d;
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] e, input string tag);
        rdy_in = 1'b1;
        mem_a  = a;
        mem_wr = 1'b0;
        rd_q.push_back(e);
        rd_tag.push_back(tag);
        rd_pend = 1'b1;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        rst_in = 1'b0;
        chk("rst_mem_din", 32'(mem_din), 32'h00);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_io_full", 32'(io_buffer_full), 32'd0);
        chk("rst_stop", 32'(program_stop), 32'd0);
        chk("rst_overflow", 32'(tx_overflow), 32'd0);

        // RAM pipeline, read-after-write, aliasing and rdy gating
        wr(32'h0001_FFFF, 8'h3C, 1'b1); tick();
        wr(32'h0000_0010, 8'hA5, 1'b1); tick();
        rd(32'h0000_0010, 8'hA5, "ram_raw_10"); tick();
        rd(32'h0001_FFFF, 8'h3C, "ram_1ffff"); tick();
        tick();
        chk("mem_din_hold", 32'(mem_din), 32'h3C);
        wr(32'h0000_0010, 8'h55, 1'b0); tick();
        rd(32'h0002_0010, 8'hA5, "ram_alias_gated"); tick();
        wr(32'h0000_0010, 8'h00, 1'b1); tick();
        chk("mem_din_hold_wr", 32'(mem_din), 32'hA5);

        // Output stream with null filtering and undefined offsets
        tx_ready = 1'b1;
        wr(32'h0003_0000, 8'h48, 1'b1); tx_q.push_back(8'h48); tick();
        wr(32'h0003_0000, 8'h00, 1'b1); tick();
        wr(32'h0003_0000, 8'h69, 1'b1); tx_q.push_back(8'h69); tick();
        wr(32'h0003_0001, 8'h77, 1'b1); tick();
        rd(32'h0003_0002, 8'h00, "io_rd_undef"); tick();
        tick(); tick();
        chk("stream_drained", 32'(tx_q.size()), 32'd0);
        chk("stream_tx_valid", 32'(tx_valid), 32'd0);
        chk("stream_overflow", 32'(tx_overflow), 32'd0);

        // Backpressure: 8 accepted, 9th dropped
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr(32'h0003_0000, 8'(8'h81 + i), 1'b1);
            if (i < 8) tx_q.push_back(8'(8'h81 + i));
            tick();
            chk($sformatf("bp_io_full_%0d", i), 32'(io_buffer_full), 32'(i + 1 >= 7));
            chk($sformatf("bp_overflow_%0d", i), 32'(tx_overflow), 32'(i == 8));
        end
        tx_ready = 1'b1;
        repeat (10) tick();
        chk("bp_drained", 32'(tx_q.size()), 32'd0);
        chk("bp_tx_valid", 32'(tx_valid), 32'd0);
        chk("bp_io_full_end", 32'(io_buffer_full), 32'd0);
        chk("bp_overflow_sticky", 32'(tx_overflow), 32'd1);

        // Input holding register
        rx_data = 8'h37; rx_valid = 1'b1; tick();
        chk("rx_ready_fall", 32'(rx_ready), 32'd0);
        rx_data = 8'h99; tick();
        rx_valid = 1'b0;
        rd(32'h0003_0000, 8'h37, "rx_read"); tick();
        chk("rx_ready_rise", 32'(rx_ready), 32'd1);
        rd(32'h0003_0000, 8'h00, "rx_read_empty"); tick();

        // Stop flag with rdy gating
        wr(32'h0003_0004, 8'hFF, 1'b0); tick();
        chk("stop_gated", 32'(program_stop), 32'd0);
        chk("stop_gated_tx", 32'(tx_valid), 32'd0);
        wr(32'h0003_0004, 8'hFF, 1'b1); tx_q.push_back(8'h00); tick();
        chk("stop_set", 32'(program_stop), 32'd1);
        tick();
        chk("stop_null_sent", 32'(tx_q.size()), 32'd0);

        // Reset mid-drain with data pending everywhere
        tx_ready = 1'b0;
        wr(32'h0003_0000, 8'h11, 1'b1); tx_q.push_back(8'h11); tick();
        wr(32'h0003_0000, 8'h22, 1'b1); tx_q.push_back(8'h22); tick();
        wr(32'h0003_0000, 8'h33, 1'b1); tx_q.push_back(8'h33);
        rx_data = 8'h5A; rx_valid = 1'b1; tick();
        rx_valid = 1'b0;
        tx_ready = 1'b1; tick();
        rst_in = 1'b1;
        rdy_in = 1'b1; mem_a = 32'h0001_FFFF; mem_wr = 1'b0;
        tick();
        rst_in = 1'b0;
        tx_q.delete();
        chk("mid_rst_mem_din", 32'(mem_din), 32'h00);
        chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_tx_data", 32'(tx_data), 32'h00);
        chk("mid_rst_io_full", 32'(io_buffer_full), 32'd0);
        chk("mid_rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("mid_rst_stop", 32'(program_stop), 32'd0);
        chk("mid_rst_overflow", 32'(tx_overflow), 32'd0);
        tick();
        chk("post_rst_mem_din", 32'(mem_din), 32'h00);
        rd(32'h0000_0010, 8'h00, "ram_kept_10"); tick();
        rd(32'h0001_FFFF, 8'h3C, "ram_kept_1ffff"); tick();

        // Counter snapshot after a long idle
        repeat (66000) tick();
        snap_exp = tb_cyc;
        rd(32'h0003_0004, snap_exp[7:0], "cnt_b0"); tick();
        repeat (3) tick();
        rd(32'h0003_0005, snap_exp[15:8], "snap_b1"); tick();
        rd(32'h0003_0006, snap_exp[23:16], "snap_b2"); tick();
        rd(32'h0003_0007, snap_exp[31:24], "snap_b3"); tick();
        rd(32'h0003_0003, 8'h00, "io_rd_off3"); tick();
        chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
